instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch and length-decode front end. Drives the byte address of the combinational program memory, takes the returned 32-bit big-endian byte window, and buffers the bytes in a byte queue. It splits the stream into variable-length x86 (IA-32 subset) instructions and hands one instruction per cycle to the decoder over a valid/ready handshake. It sits between program memory and the decode/execute stage, and accepts branch redirects from execute.

## Interface

- RESET_PC, 32'h0000_0000, fetch address and PC loaded on reset
- QDEPTH, 12, byte-queue depth in bytes (must be ≥ 11)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- mem_addr  out  32  byte address to program memory
- mem_ope  in  32  bytes at mem_addr..mem_addr+3; mem_ope[31:24] = byte at mem_addr
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address / PC
- instr_valid  out  1  head instruction complete and offered
- instr_ready  in  1  decoder accepts the head instruction
- instr_bytes  out  56  instruction left-justified; byte 0 at [55:48]; unused bytes zero
- instr_len  out  3  length in bytes, 1..7
- instr_pc  out  32  address of byte 0
- instr_illegal  out  1  head opcode or ModRM form is unsupported

## Operation

- State: fetch_addr (32), queue of QDEPTH bytes with count, head_pc (32), FSM {RUN, HALT}.
- Reset: fetch_addr = head_pc = RESET_PC, count = 0, FSM = RUN. Outputs: mem_addr = RESET_PC, instr_valid = 0, instr_bytes = 0, instr_len = 1, instr_pc = RESET_PC, instr_illegal = 0.
- mem_addr = fetch_addr (combinational).
- Fetch:
  - Condition: FSM = RUN, no redirect, and QDEPTH − count ≥ 4. Free space is counted before any pop in the same cycle.
  - Action: append mem_ope bytes [31:24], [23:16], [15:8], [7:0] in that order; fetch_addr += 4 (mod 2^32).
- Length decode of the head (op = byte0, m = byte1; mod = m[7:6], rm = m[2:0]):
  - 1 byte: 55, 5D, C3, C9, 90
  - 2 bytes: 6A (imm8)
  - 5 bytes: E8 (rel32)
  - ModRM forms: 89, 8B → 2 + disp; 83 → 3 + disp
  - disp = 0 (mod 11), 1 (mod 01), 4 (mod 10), 0 (mod 00 with rm ≠ 100, rm ≠ 101)
  - Illegal: any other opcode, or a ModRM form with rm = 100 and mod ≠ 11, or mod 00 with rm = 101. Illegal reports instr_len = 1 with instr_illegal = 1.
- Readiness:
  - Length is known when count ≥ 1 for non-ModRM opcodes, and count ≥ 2 for ModRM opcodes.
  - instr_valid = length known ∧ count ≥ instr_len ∧ ¬redirect_valid.
- Transfer (instr_valid ∧ instr_ready): pop instr_len bytes; head_pc += instr_len; count is updated by push and pop together in the same edge.
- HALT: entered when an illegal instruction transfers. Fetch stops; the remaining queue contents continue to be offered. Only redirect_valid leaves HALT.
- Redirect:
  - Has priority over fetch and transfer.
  - At the edge: count = 0, fetch_addr = head_pc = redirect_pc, FSM = RUN.
  - instr_valid is 0 in the redirect cycle, so no transfer occurs.

## Timing

- Memory read is zero-latency; fetched bytes are visible in the queue one cycle after mem_addr is presented.
- Reset release to first instr_valid:
  - 1 edge for 1–4-byte instructions.
  - 2 edges for 5–7-byte instructions, provided the queue is otherwise idle.
- Throughput is at most 1 instruction per cycle and at most 4 fetched bytes per cycle.
- Full queue: fetch stalls and mem_addr is held.
- Empty queue: instr_valid = 0.
- instr_valid, once high, stays high with stable outputs until transfer or redirect; stalling never drops an instruction.
- Asynchronous reset mid-operation discards the queue immediately.

## Test plan

- **Basic stream.** Memory at 0 holds 55 89 E5 8B 45 08 83 E8 01 5D C3, ready = 1. Required: (pc, len) = (0,1), (1,2), (3,3), (6,3), (9,1), (10,1); instr_bytes of the third instruction = 8B4508_00000000.
- **Push and call.** Memory at 11 holds 55 89 E5 6A 0A E8 EB FF FF FF; redirect to 11. Required: lengths 1,2,2,5; the E8 instruction has pc = 16 and bytes E8EBFFFFFF_0000.
- **Back-pressure.** Same stream as the basic stream with ready = 0 for 10 cycles. Required: count saturates without exceeding QDEPTH; mem_addr stops advancing; instr_valid stays high with pc = 0 and len = 1 throughout; after ready returns, the sequence is identical to the basic stream.
- **Redirect mid-transfer.** Assert redirect_valid to 0x20 while instr_valid = 1 and ready = 1. Required: no transfer in that cycle; the next cycle has count = 0 and mem_addr = 0x20; the first instruction offered afterwards has pc = 0x20.
- **Illegal opcode.** Memory at 0 holds 0F 55. Required: (pc 0, len 1, illegal = 1); after it transfers, FSM = HALT and mem_addr freezes; 55 is still offered at pc 1; a redirect resumes fetching.
- **Asynchronous reset.** Drop reset between clock edges with a half-full queue. Required: instr_valid = 0 and mem_addr = RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch and length-decode front end.
// Fetches 4-byte big-endian windows from a combinational program memory into a
// byte queue. It splits the byte stream into IA-32 subset instructions and offers
// one instruction per cycle to the decoder over a valid/ready handshake.
// Branch redirects from execute flush the queue and restart fetch.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 12
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_ope,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [55:0] instr_bytes,
   output logic [2:0]  instr_len,
   output logic [31:0] instr_pc,
   output logic        instr_illegal
);

   localparam int CW = $clog2(QDEPTH + 1);
   localparam int IW = $clog2(QDEPTH);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [31:0]   fetch_addr, head_pc;
   logic [CW-1:0] count, count_nxt;
   logic [7:0]    q     [QDEPTH];
   logic [7:0]    q_nxt [QDEPTH];
   logic [7:0]    fetch_byte [4];

   logic       is_modrm, op_legal, modrm_bad, len_known;
   logic       fetch_en, pop, dec_illegal;
   logic [2:0] base_len, disp_len, dec_len;
   logic [1:0] mod;
   logic [2:0] rm;

   assign mem_addr = fetch_addr;
   assign instr_pc = head_pc;
   assign instr_len = dec_len;
   assign instr_illegal = dec_illegal;

   assign mod = q[1][7:6];
   assign rm  = q[1][2:0];

   assign fetch_byte[0] = mem_ope[31:24];
   assign fetch_byte[1] = mem_ope[23:16];
   assign fetch_byte[2] = mem_ope[15:8];
   assign fetch_byte[3] = mem_ope[7:0];

   // Opcode classification: base length and whether a ModRM byte follows.
   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      is_modrm = 1'b0;
      op_legal = 1'b1;
      base_len = 3'd1;
      case (q[0])
         8'h55, 8'h5D, 8'hC3, 8'hC9, 8'h90: base_len = 3'd1;
         8'h6A:        base_len = 3'd2;
         8'hE8:        base_len = 3'd5;
         8'h89, 8'h8B: begin is_modrm = 1'b1; base_len = 3'd2; end
         8'h83:        begin is_modrm = 1'b1; base_len = 3'd3; end
         default:      op_legal = 1'b0;
      endcase
   end

   // Displacement size and unsupported addressing forms (SIB, disp32-only).
   always_comb begin
      case (mod)
         2'b01:   disp_len = 3'd1;
         2'b10:   disp_len = 3'd4;
         default: disp_len = 3'd0;
      endcase
      modrm_bad = ((rm == 3'b100) && (mod != 2'b11)) || ((mod == 2'b00) && (rm == 3'b101));
   end

   // Head length resolution; an unknown or illegal head reports length 1.
   always_comb begin
      len_known   = (count != '0) && (!is_modrm || (count >= CW'(2)));
      dec_len     = 3'd1;
      dec_illegal = 1'b0;
      if (len_known) begin
         if (!op_legal || (is_modrm && modrm_bad)) dec_illegal = 1'b1;
         else dec_len = base_len + (is_modrm ? disp_len : 3'd0);
      end
   end

   assign instr_valid = len_known && (count >= CW'(dec_len)) && !redirect_valid;
   assign pop         = instr_valid && instr_ready;
   // Free space is judged before any same-cycle pop, so a full queue stalls for one cycle.
   assign fetch_en    = (state == RUN) && !redirect_valid && (count <= CW'(QDEPTH - 4));
   assign count_nxt   = count - CW'(pop ? dec_len : 3'd0) + (fetch_en ? CW'(4) : CW'(0));

   // Left-justified instruction bytes; bytes beyond the length or the valid data read as zero.
   always_comb begin
      instr_bytes = '0;
      for (int i = 0; i < 7; i++) begin
         if ((3'(i) < dec_len) && (CW'(i) < count)) instr_bytes[55 - 8*i -: 8] = q[IW'(i)];
      end
   end

   // Next queue contents: shift out the popped bytes, then append the fetched window.
   always_comb begin : queue_next
      int pop_n;
      int wr_base;
      pop_n   = pop ? int'(dec_len) : 0;
      wr_base = int'(count) - pop_n;
      for (int i = 0; i < QDEPTH; i++) begin
         if (i + pop_n < QDEPTH) q_nxt[IW'(i)] = q[IW'(i + pop_n)];
         else q_nxt[IW'(i)] = q[IW'(i)];
         if (fetch_en && (i >= wr_base) && (i < wr_base + 4)) q_nxt[IW'(i)] = fetch_byte[2'(i - wr_base)];
      end
   end

   // Fetch address, head PC and byte count; redirect overrides fetch and transfer.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_addr <= RESET_PC;
         head_pc    <= RESET_PC;
         count      <= '0;
      end else if (redirect_valid) begin
         fetch_addr <= redirect_pc;
         head_pc    <= redirect_pc;
         count      <= '0;
      end else begin
         if (fetch_en) fetch_addr <= fetch_addr + 32'd4;
         if (pop) head_pc <= head_pc + 32'(dec_len);
         count <= count_nxt;
      end
   end

   // Queue storage.
   // NOTE: the byte array has no reset; count alone decides which bytes are meaningful.
   always_ff @(posedge clk) begin
      for (int i = 0; i < QDEPTH; i++) q[IW'(i)] <= q_nxt[IW'(i)];
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= RUN;
      else state <= state_nxt;
   end

   // FSM next state: an accepted illegal instruction halts fetch until a redirect.
   always_comb begin
      state_nxt = state;
      if (redirect_valid) state_nxt = RUN;
      else if (pop && dec_illegal) state_nxt = HALT;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus a randomized run
// checked against an instruction-level model that walks program memory.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          QDEPTH   = 12;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_ope;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [55:0] instr_bytes;
   logic [2:0]  instr_len;
   logic [31:0] instr_pc;
   logic        instr_illegal;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] mem [256];
   int         starts [256];
   int         nstarts;
   logic [7:0] a0, a1, a2, a3;

   logic [7:0] basic_prog [11] = '{8'h55, 8'h89, 8'hE5, 8'h8B, 8'h45, 8'h08, 8'h83, 8'hE8, 8'h01, 8'h5D, 8'hC3};
   logic [7:0] call_prog  [10] = '{8'h55, 8'h89, 8'hE5, 8'h6A, 8'h0A, 8'hE8, 8'hEB, 8'hFF, 8'hFF, 8'hFF};
   logic [7:0] ops1       [5]  = '{8'h55, 8'h5D, 8'hC3, 8'hC9, 8'h90};
   logic [7:0] ops_modrm  [3]  = '{8'h89, 8'h8B, 8'h83};

   always #5 clk = ~clk;

   // Zero-latency program memory, 256 bytes wrapping.
   always_comb begin
      a0 = mem_addr[7:0];
      a1 = a0 + 8'd1;
      a2 = a0 + 8'd2;
      a3 = a0 + 8'd3;
      mem_ope = {mem[a0], mem[a1], mem[a2], mem[a3]};
   end

   instr_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_ope(mem_ope),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_bytes(instr_bytes),
      .instr_len(instr_len), .instr_pc(instr_pc), .instr_illegal(instr_illegal)
   );

   function automatic logic [7:0] rdb(input logic [31:0] a);
      return mem[a[7:0]];
   endfunction

   // Reference length decode straight from the instruction-set rules.
   function automatic int ref_len(input logic [31:0] pc, output bit illegal);
      logic [7:0] op, m;
      int base;
      bit modrm;
      op = rdb(pc);
      m = rdb(pc + 32'd1);
      illegal = 1'b0;
      modrm = 1'b0;
      base = 1;
      case (op)
         8'h55, 8'h5D, 8'hC3, 8'hC9, 8'h90: base = 1;
         8'h6A: base = 2;
         8'hE8: base = 5;
         8'h89, 8'h8B: begin modrm = 1'b1; base = 2; end
         8'h83: begin modrm = 1'b1; base = 3; end
         default: begin illegal = 1'b1; return 1; end
      endcase
      if (modrm) begin
         if ((m[2:0] == 3'd4 && m[7:6] != 2'd3) || (m[7:6] == 2'd0 && m[2:0] == 3'd5)) begin
            illegal = 1'b1;
            return 1;
         end
         if (m[7:6] == 2'd1) base += 1;
         else if (m[7:6] == 2'd2) base += 4;
      end
      return base;
   endfunction

   function automatic logic [55:0] ref_bytes(input logic [31:0] pc, input int len);
      logic [55:0] b;
      b = '0;
      for (int k = 0; k < len; k++) b[55 - 8*k -: 8] = rdb(pc + 32'(k));
      return b;
   endfunction

   task automatic load_directed();
      for (int i = 0; i < 256; i++) mem[i] = 8'h90;
      for (int i = 0; i < 11; i++) mem[i] = basic_prog[i];
      for (int i = 0; i < 10; i++) mem[11 + i] = call_prog[i];
   endtask

   // Random legal program filling memory; tail padded with 1-byte NOPs so the wrap is clean.
   task automatic gen_program();
      int p, ln;
      logic [7:0] op, m;
      logic [1:0] md;
      logic [2:0] rm;
      p = 0;
      nstarts = 0;
      while (p < 240) begin
         starts[nstarts] = p;
         nstarts++;
         for (int k = 0; k < 7; k++) mem[p + k] = 8'($urandom);
         case ($urandom_range(3))
            0: begin mem[p] = ops1[$urandom_range(4)]; ln = 1; end
            1: begin mem[p] = 8'h6A; ln = 2; end
            2: begin mem[p] = 8'hE8; ln = 5; end
            default: begin
               op = ops_modrm[$urandom_range(2)];
               md = 2'($urandom);
               rm = 3'($urandom);
               if (rm == 3'd4 && md != 2'd3) rm = 3'd0;
               if (md == 2'd0 && rm == 3'd5) rm = 3'd1;
               m = {md, 3'($urandom), rm};
               mem[p] = op;
               mem[p + 1] = m;
               ln = ((op == 8'h83) ? 3 : 2) + ((md == 2'd1) ? 1 : (md == 2'd2) ? 4 : 0);
            end
         endcase
         p += ln;
      end
      while (p < 256) begin
         starts[nstarts] = p;
         nstarts++;
         mem[p] = 8'h90;
         p++;
      end
   endtask

   // Holds reset over one edge and releases it on a falling edge.
   task automatic do_reset();
      reset = 1'b0;
      instr_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      @(posedge clk); #1;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Watches for the six basic-stream transfers (ready must already be high).
   task automatic run_basic_stream(input string tag);
      int pcs [6] = '{0, 1, 3, 6, 9, 10};
      int lens [6] = '{1, 2, 3, 3, 1, 1};
      int idx = 0;
      for (int c = 0; c < 40 && idx < 6; c++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            vectors++; if (instr_pc !== 32'(pcs[idx])) begin miscompares++; $display("FAIL %s_pc%0d: got %0d expected %0d", tag, idx, instr_pc, pcs[idx]); end
            vectors++; if (instr_len !== 3'(lens[idx])) begin miscompares++; $display("FAIL %s_len%0d: got %0d expected %0d", tag, idx, instr_len, lens[idx]); end
            vectors++; if (instr_illegal !== 1'b0) begin miscompares++; $display("FAIL %s_ill%0d: got %b expected 0", tag, idx, instr_illegal); end
            if (idx == 2) begin
               vectors++; if (instr_bytes !== 56'h8B450800000000) begin miscompares++; $display("FAIL %s_bytes: got %h expected 8b450800000000", tag, instr_bytes); end
            end
            idx++;
         end
      end
      vectors++; if (idx != 6) begin miscompares++; $display("FAIL %s_timeout: got %0d transfers expected 6", tag, idx); end
   endtask

   task automatic test_reset();
      load_directed();
      reset = 1'b0;
      @(posedge clk); #1;
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
      vectors++; if (mem_addr !== RESET_PC) begin miscompares++; $display("FAIL reset_addr: got %h expected %h", mem_addr, RESET_PC); end
      vectors++; if (instr_bytes !== 56'h0) begin miscompares++; $display("FAIL reset_bytes: got %h expected 0", instr_bytes); end
      vectors++; if (instr_len !== 3'd1) begin miscompares++; $display("FAIL reset_len: got %0d expected 1", instr_len); end
      vectors++; if (instr_pc !== RESET_PC) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", instr_pc, RESET_PC); end
      vectors++; if (instr_illegal !== 1'b0) begin miscompares++; $display("FAIL reset_ill: got %b expected 0", instr_illegal); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_basic();
      load_directed();
      do_reset();
      instr_ready = 1'b1;
      @(posedge clk); #1;
      vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL first_valid_latency: got %b expected 1", instr_valid); end
      run_basic_stream("basic");
   endtask

   task automatic test_push_call();
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      redirect_pc = 32'd11;
      @(negedge clk);
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL call_redirect_valid: got %b expected 0", instr_valid); end
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      begin
         int pcs [4] = '{11, 12, 14, 16};
         int lens [4] = '{1, 2, 2, 5};
         int idx = 0;
         for (int c = 0; c < 40 && idx < 4; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
               vectors++; if (instr_pc !== 32'(pcs[idx])) begin miscompares++; $display("FAIL call_pc%0d: got %0d expected %0d", idx, instr_pc, pcs[idx]); end
               vectors++; if (instr_len !== 3'(lens[idx])) begin miscompares++; $display("FAIL call_len%0d: got %0d expected %0d", idx, instr_len, lens[idx]); end
               if (idx == 3) begin
                  vectors++; if (instr_bytes !== 56'hE8EBFFFFFF0000) begin miscompares++; $display("FAIL call_bytes: got %h expected e8ebffffff0000", instr_bytes); end
               end
               idx++;
            end
         end
         vectors++; if (idx != 4) begin miscompares++; $display("FAIL call_timeout: got %0d transfers expected 4", idx); end
      end
   endtask

   task automatic test_back_pressure();
      int exp_fill;
      load_directed();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         exp_fill = 4 * (((c + 1) < (QDEPTH / 4)) ? (c + 1) : (QDEPTH / 4));
         vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr_len !== 3'd1) begin miscompares++; $display("FAIL bp_hold%0d: got v=%b pc=%0d len=%0d expected v=1 pc=0 len=1", c, instr_valid, instr_pc, instr_len); end
         vectors++; if (mem_addr !== 32'(exp_fill)) begin miscompares++; $display("FAIL bp_addr%0d: got %0d expected %0d", c, mem_addr, exp_fill); end
         vectors++; if (int'(dut.count) != exp_fill) begin miscompares++; $display("FAIL bp_count%0d: got %0d expected %0d", c, dut.count, exp_fill); end
      end
      @(posedge clk); #1;
      instr_ready = 1'b1;
      run_basic_stream("bp");
   endtask

   task automatic test_redirect_mid();
      load_directed();
      do_reset();
      instr_ready = 1'b1;
      @(negedge clk);
      vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL rd_pre_valid: got %b expected 1", instr_valid); end
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h20;
      @(negedge clk);
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rd_cycle_valid: got %b expected 0", instr_valid); end
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      vectors++; if (mem_addr !== 32'h20) begin miscompares++; $display("FAIL rd_addr: got %h expected 20", mem_addr); end
      vectors++; if (int'(dut.count) != 0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL rd_flush: got count=%0d v=%b expected count=0 v=0", dut.count, instr_valid); end
      @(negedge clk);
      vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20) begin miscompares++; $display("FAIL rd_first: got v=%b pc=%h expected v=1 pc=20", instr_valid, instr_pc); end
   endtask

   task automatic test_async_reset();
      load_directed();
      do_reset();
      @(negedge clk);
      @(negedge clk);
      vectors++; if (mem_addr !== 32'd8) begin miscompares++; $display("FAIL ar_pre_addr: got %0d expected 8", mem_addr); end
      #2;
      reset = 1'b0;
      #1;
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL ar_valid: got %b expected 0", instr_valid); end
      vectors++; if (mem_addr !== RESET_PC || instr_pc !== RESET_PC) begin miscompares++; $display("FAIL ar_addr: got addr=%h pc=%h expected %h", mem_addr, instr_pc, RESET_PC); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_illegal();
      load_directed();
      mem[0] = 8'h0F;
      mem[1] = 8'h55;
      for (int i = 2; i < 16; i++) mem[i] = 8'h90;
      do_reset();
      instr_ready = 1'b1;
      @(negedge clk);
      vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr_len !== 3'd1 || instr_illegal !== 1'b1) begin miscompares++; $display("FAIL ill_head: got v=%b pc=%0d len=%0d ill=%b expected 1 0 1 1", instr_valid, instr_pc, instr_len, instr_illegal); end
      vectors++; if (instr_bytes !== 56'h0F000000000000) begin miscompares++; $display("FAIL ill_bytes: got %h expected 0f000000000000", instr_bytes); end
      @(posedge clk); #1;
      instr_ready = 1'b0;
      @(negedge clk);
      vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'd1 || instr_len !== 3'd1 || instr_illegal !== 1'b0) begin miscompares++; $display("FAIL ill_next: got v=%b pc=%0d len=%0d ill=%b expected 1 1 1 0", instr_valid, instr_pc, instr_len, instr_illegal); end
      vectors++; if (instr_bytes !== 56'h55000000000000) begin miscompares++; $display("FAIL ill_next_bytes: got %h expected 55000000000000", instr_bytes); end
      for (int c = 0; c < 6; c++) begin
         if (c == 3) begin @(posedge clk); #1; instr_ready = 1'b1; end
         @(negedge clk);
         vectors++; if (mem_addr !== 32'd8) begin miscompares++; $display("FAIL ill_freeze%0d: got %0d expected 8", c, mem_addr); end
      end
      @(posedge clk); #1;
      instr_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      vectors++; if (mem_addr !== 32'h40) begin miscompares++; $display("FAIL ill_resume_addr: got %h expected 40", mem_addr); end
      @(negedge clk);
      vectors++; if (mem_addr !== 32'h44 || instr_valid !== 1'b1 || instr_pc !== 32'h40) begin miscompares++; $display("FAIL ill_resume: got addr=%h v=%b pc=%h expected 44 1 40", mem_addr, instr_valid, instr_pc); end
   endtask

   // Random ready and redirects against the instruction-level model.
   task automatic test_random();
      logic [31:0] exp_pc, h_pc;
      logic [2:0]  h_len;
      logic [55:0] h_bytes, rb;
      bit          hold, ril;
      int          idle, rl;
      gen_program();
      do_reset();
      exp_pc = RESET_PC;
      hold = 1'b0;
      idle = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         instr_ready = ($urandom_range(3) != 0);
         if ($urandom_range(24) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc = 32'(starts[$urandom_range(nstarts - 1)]);
         end else begin
            redirect_valid = 1'b0;
         end
         @(negedge clk);
         if (redirect_valid) begin
            vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_redirect_valid c%0d: got %b expected 0", c, instr_valid); end
            exp_pc = redirect_pc;
            hold = 1'b0;
            idle = 0;
         end else begin
            if (hold) begin
               vectors++; if (instr_valid !== 1'b1 || instr_pc !== h_pc || instr_len !== h_len || instr_bytes !== h_bytes) begin miscompares++; $display("FAIL rnd_stable c%0d: got v=%b pc=%h len=%0d expected v=1 pc=%h len=%0d", c, instr_valid, instr_pc, instr_len, h_pc, h_len); end
            end
            if (instr_valid) begin
               idle = 0;
               rl = ref_len(exp_pc, ril);
               rb = ref_bytes(exp_pc, rl);
               vectors++; if (instr_pc !== exp_pc) begin miscompares++; $display("FAIL rnd_pc c%0d: got %h expected %h", c, instr_pc, exp_pc); end
               vectors++; if (instr_len !== 3'(rl) || instr_illegal !== ril) begin miscompares++; $display("FAIL rnd_len c%0d: got len=%0d ill=%b expected len=%0d ill=%b", c, instr_len, instr_illegal, rl, ril); end
               vectors++; if (instr_bytes !== rb) begin miscompares++; $display("FAIL rnd_bytes c%0d: got %h expected %h", c, instr_bytes, rb); end
               if (instr_ready) exp_pc = exp_pc + 32'(rl);
               hold = !instr_ready;
               h_pc = instr_pc;
               h_len = instr_len;
               h_bytes = instr_bytes;
            end else begin
               hold = 1'b0;
               idle++;
               vectors++;
               if (idle > 8) begin
                  miscompares++;
                  $display("FAIL rnd_starve c%0d: got %0d idle cycles expected at most 8", c, idle);
                  break;
               end
            end
         end
      end
      redirect_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_push_call();
      test_back_pressure();
      test_redirect_mid();
      test_async_reset();
      test_illegal();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
